// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 serial receive front-end with mid-bit sampling,
// a first-word-fall-through byte FIFO and sticky error flags.
// Optional build macro UART_RX_PARITY_EN: frames become 8E1, a PARITY state
// follows DATA and a sticky parity_err output is added.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle; waiting for a falling edge on the synchronised line
// S_START | half-bit wait, then confirm start bit is still low
// S_DATA  | sample 8 data bits at mid-bit, LSB first
// S_PARITY| (8E1 build only) sample the even-parity bit
// S_STOP  | sample stop bit; push byte or flag a framing error
module uart_rx_deframer #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic       clk,
   input  logic       nReset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overflow,
   input  logic       err_clear,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       busy
);

   localparam int          CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int          HALF         = CLKS_PER_BIT / 2;
   localparam logic [15:0] CNT_BIT      = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] CNT_HALF     = 16'(HALF - 1);
   localparam int          AW           = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q;
   logic [1:0]  warm_q;
   logic        armed_q, armed_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        frame_err_q, overflow_q;
   logic        push, fe_set;
   logic        rxs;
`ifdef UART_RX_PARITY_EN
   logic        par_bad_q, par_bad_d;
   logic        parity_err_q;
   logic        pe_set;
`endif

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        fifo_full, fifo_empty, pop, push_ok, ovf_set;

   assign rxs = sync2_q;

   // Two-flop synchroniser (resets to idle-high) plus a warm-up shift register.
   // The reset-value 1s in the synchroniser must not count as "line seen high",
   // otherwise a line held low across reset would look like a fresh start edge.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         warm_q  <= 2'b00;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         warm_q  <= {warm_q[0], 1'b1};
      end
   end

   // Deframer state register.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_q <= S_IDLE;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
`endif
      end
   end

   // Deframer next-state: down-counter terminal count drives every sample point.
   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      push    = 1'b0;
      fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      pe_set    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (rxs) begin
               if (warm_q[1]) armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = S_START;
               cnt_d   = CNT_HALF;
               armed_d = 1'b0;
            end
         end
         S_START: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (!rxs) begin
               state_d = S_DATA;
               cnt_d   = CNT_BIT;
               idx_d   = 3'd0;
            end else begin
               // Start bit vanished before mid-bit: treat as a glitch.
               state_d = S_IDLE;
               armed_d = 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               shreg_d = {rxs, shreg_q[7:1]};
               cnt_d   = CNT_BIT;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d   = S_PARITY;
                  par_bad_d = 1'b0;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               cnt_d   = CNT_BIT;
               state_d = S_STOP;
               if (rxs != ^shreg_q) begin
                  pe_set    = 1'b1;
                  par_bad_d = 1'b1;
               end
            end
         end
`endif
         S_STOP: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               // Leaving in the same cycle lets a back-to-back start edge be seen next cycle.
               state_d = S_IDLE;
               armed_d = rxs;
               if (rxs) begin
`ifdef UART_RX_PARITY_EN
                  push = !par_bad_q;
`else
                  push = 1'b1;
`endif
               end else begin
                  fe_set = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = !fifo_empty && rx_ready;
   // When full, a simultaneous pop frees the slot the push writes into.
   assign push_ok    = push && (!fifo_full || pop);
   assign ovf_set    = push && fifo_full && !pop;

   // FIFO pointers; the extra MSB separates full from empty.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
   end

   // Sticky error flags; a new event in the clear cycle wins.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         frame_err_q <= (frame_err_q && !err_clear) || fe_set;
         overflow_q  <= (overflow_q && !err_clear) || ovf_set;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= (parity_err_q && !err_clear) || pe_set;
`endif
      end
   end

   assign rx_valid  = !fifo_empty;
   assign rx_data   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;
   assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule
